alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares the single combinational rv32i ALU between two requesters, req0 and req1. Typical requesters: the main datapath and a second issue/debug port.
- Grants requests round-robin, registers the granted operands onto the ALU inputs, and captures result/zero one cycle later.
- Returns result/zero to the winning requester through a valid/ready response handshake.
- Sits between the requesters and the alu instance; the alu is instantiated outside this block.

Parameters:
- WIDTH, 32, data width of operands and result.
- OP_W, 4, width of the ALU op code.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  bit i = requester i has an operation pending.
- req_ready  out  2  bit i = request i accepted this cycle (combinational).
- req0_op / req1_op  in  OP_W  ALU op per requester.
- req0_a / req1_a  in  WIDTH  operand a per requester.
- req0_b / req1_b  in  WIDTH  operand b per requester.
- rsp_valid  out  2  bit i = response for requester i held valid.
- rsp_ready  in  2  bit i = requester i consumes response.
- rsp_result  out  WIDTH  captured ALU result.
- rsp_zero  out  1  captured ALU zero flag.
- rsp_err  out  1  op was not a supported code.
- alu_op  out  OP_W  registered op to ALU.
- alu_a  out  WIDTH  registered operand a to ALU.
- alu_b  out  WIDTH  registered operand b to ALU.
- alu_result  in  WIDTH  ALU result.
- alu_zero  in  1  ALU zero flag.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Supported ops: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB. Any other code is forwarded unchanged; the ALU returns 0 with zero=1, and rsp_err=1 for that response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant computed combinationally from req_valid and priority pointer prio (0 favours req0, 1 favours req1).
  - If both are valid, the prio requester wins.
  - If one is valid, it wins regardless of prio.
  - req_ready[g] = 1 only for the winner; it is 0 in EXEC and RESP.
  - On a handshake edge: alu_op/alu_a/alu_b <= winner's fields; owner <= g; err_q <= op unsupported; prio <= ~g; state -> EXEC.
  - No valid request: stay in IDLE; alu_* hold their values.
- EXEC:
  - ALU evaluates the registered operands.
  - Next edge: rsp_result <= alu_result, rsp_zero <= alu_zero, rsp_err <= err_q; state -> RESP.
- RESP:
  - rsp_valid[owner] = 1; the other bit is 0.
  - rsp_result, rsp_zero and rsp_err are held stable until consumed.
  - Edge with rsp_ready[owner]=1: state -> IDLE.
  - rsp_ready of the non-owner is ignored.
- Latency: handshake at edge T; response valid from edge T+2; earliest next grant is edge T+3. Throughput is at most one op per 3 cycles.
- Requester data is sampled only at its handshake edge; later changes to it do not affect the captured op.
- req_valid may drop without a handshake; no grant occurs and prio is unchanged.
- A requester that keeps req_valid high while waiting is never starved: after the other requester's grant, prio points to it.
- Reset (any state, including mid-EXEC/RESP):
  - State -> IDLE; prio=0; owner=0.
  - alu_op, alu_a, alu_b, rsp_result, rsp_err = 0; rsp_zero = 0.
  - rsp_valid = 00, req_ready = 00 during reset, busy = 0.
  - Any in-flight operation is dropped with no response.
- Widths: all data is WIDTH bits. No arithmetic is done in this block; overflow and wrap follow the ALU (ADD/SUB modulo 2^WIDTH).

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then no requests -> rsp_valid=00, req_ready=00, busy=0, alu_a=0 throughout.
- Single ADD: req0 valid, op=0010, a=5, b=7 at edge T -> req_ready=01 at T. At T+2: rsp_valid=01, rsp_result=12, rsp_zero=0, rsp_err=0. Response held until rsp_ready[0]=1.
- Contention and round-robin: both valid continuously after reset; req0 SUB 9-9, req1 OR 0xF0|0x0F.
  - Grant order is req0, req1, req0.
  - req0 response: result=0, zero=1.
  - req1 response: result=0xFF, zero=0.
  - No grant occurs while busy=1.
- Backpressure and wrap: req1 ADD 0xFFFFFFFF+1 with rsp_ready=0 for 5 cycles -> rsp_valid=10 and rsp_result=0, zero=1, all stable for 5 cycles. New req0 valid meanwhile gets req_ready=0. Response releases on rsp_ready=10.
- Illegal op: req0 op=0011, a=3, b=4 -> rsp_result=0, rsp_zero=1, rsp_err=1.
- Reset mid-op: assert rst during EXEC, then during RESP -> next cycle state IDLE, rsp_valid=00, prio=0 (simultaneous requests then grant req0 first), no stale response appears.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Grants in IDLE, drives registered operands in EXEC, and holds the response in RESP until it is consumed.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_b,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [OP_W-1:0]  alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             owner_q, owner_d;
  logic             err_q, err_d;
  logic [OP_W-1:0]  alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;

  logic             gnt_idx;
  logic [1:0]       grant;
  logic [OP_W-1:0]  win_op;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic             win_unsupported;

  // Contention goes to prio; a lone requester wins whatever prio says.
  always_comb begin
    grant   = '0;
    gnt_idx = (&req_valid) ? prio_q : req_valid[1];
    if (state_q == IDLE && !rst && (|req_valid)) begin
      grant = gnt_idx ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    win_op = gnt_idx ? req1_op : req0_op;
    win_a  = gnt_idx ? req1_a  : req0_a;
    win_b  = gnt_idx ? req1_b  : req0_b;
    win_unsupported = !((win_op == OP_W'(4'b0000)) || (win_op == OP_W'(4'b0001)) ||
                        (win_op == OP_W'(4'b0010)) || (win_op == OP_W'(4'b0110)));
  end

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    owner_d      = owner_q;
    err_d        = err_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          alu_op_d = win_op;
          alu_a_d  = win_a;
          alu_b_d  = win_b;
          owner_d  = gnt_idx;
          err_d    = win_unsupported;
          prio_d   = ~gnt_idx;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        rsp_err_d    = err_q;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      owner_q      <= 1'b0;
      err_q        <= 1'b0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      owner_q      <= owner_d;
      err_q        <= err_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  always_comb begin
    req_ready  = grant;
    rsp_valid  = (state_q == RESP && !rst) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    rsp_result = rsp_result_q;
    rsp_zero   = rsp_zero_q;
    rsp_err    = rsp_err_q;
    alu_op     = alu_op_q;
    alu_a      = alu_a_q;
    alu_b      = alu_b_q;
    busy       = (state_q != IDLE);
  end

endmodule
